// File: rtl/alu_writeback.sv
// alu_writeback: two-entry in-order result buffer between the 16-bit ALU and
// the register-file write port. Each entry carries the width-masked result,
// destination index and precomputed {C, Z, N}. The architectural flag
// register is updated in program order as entries retire.
module alu_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] z,
    input  logic        c_out8,
    input  logic        c_out16,
    input  logic        width16,
    input  logic [2:0]  dest,
    input  logic        flags_we,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_dest,
    output logic [2:0]  flags,
    input  logic        flags_wr,
    input  logic [2:0]  flags_wr_data
);

    // Only a two-entry buffer is supported; pointers are one bit each.
    localparam logic [1:0] FULL_COUNT = DEPTH[1:0];

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        fwe;
        logic        c;
        logic        zf;
        logic        n;
    } entry_t;

    // Build a buffer entry from the raw ALU outputs. 8-bit ops see only the
    // low byte: the result is zero-extended and C/Z/N come from bit 7 and
    // the low byte. Carries are taken exactly as the ALU delivers them.
    function automatic entry_t capture_entry(
        input logic [15:0] zv,
        input logic        c8,
        input logic        c16,
        input logic        w16,
        input logic [2:0]  dst,
        input logic        fwe
    );
        entry_t e;
        if (w16) begin
            e.data = zv;
            e.c    = c16;
            e.n    = zv[15];
        end else begin
            e.data = {8'h00, zv[7:0]};
            e.c    = c8;
            e.n    = zv[7];
        end
        e.zf   = (e.data == 16'h0000);
        e.dest = dst;
        e.fwe  = fwe;
        return e;
    endfunction

    entry_t      mem_r [2];
    logic        head_r;
    logic        tail_r;
    logic [1:0]  count_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [15:0] out_data_r;
    logic [2:0]  out_dest_r;
    logic [2:0]  flags_r;

    logic        push_s;
    logic        pop_s;
    logic [1:0]  count_nxt_s;
    logic        head_nxt_s;
    logic        tail_nxt_s;
    entry_t      new_entry_s;
    entry_t      head_entry_s;
    entry_t      head_entry_nxt_s;
    logic [2:0]  flags_nxt_s;

    assign push_s       = in_valid & in_ready_r;
    assign pop_s        = out_valid_r & out_ready;
    assign new_entry_s  = capture_entry(z, c_out8, c_out16, width16, dest, flags_we);
    assign head_entry_s = mem_r[head_r];

    // Occupancy and pointer advance; push+pop together leaves count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case ({push_s, pop_s})
            2'b10: begin
                count_nxt_s = count_r + 2'd1;
                tail_nxt_s  = ~tail_r;
            end
            2'b01: begin
                count_nxt_s = count_r - 2'd1;
                head_nxt_s  = ~head_r;
            end
            2'b11: begin
                tail_nxt_s  = ~tail_r;
                head_nxt_s  = ~head_r;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Entry that will sit at the head after this edge, so the output
    // registers can be loaded with it (forwarding the slot being written).
    always_comb begin
        head_entry_nxt_s = mem_r[head_nxt_s];
        if (push_s && (tail_r == head_nxt_s)) begin
            head_entry_nxt_s = new_entry_s;
        end else begin
            head_entry_nxt_s = mem_r[head_nxt_s];
        end
    end

    // Flag register next value: a direct load beats a retiring update.
    always_comb begin
        flags_nxt_s = flags_r;
        if (flags_wr) begin
            flags_nxt_s = flags_wr_data;
        end else if (pop_s && head_entry_s.fwe) begin
            flags_nxt_s = {head_entry_s.c, head_entry_s.zf, head_entry_s.n};
        end else begin
            flags_nxt_s = flags_r;
        end
    end

    // Entry storage, written at the tail on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (push_s) begin
            mem_r[tail_r] <= new_entry_s;
        end else begin
            mem_r[tail_r] <= mem_r[tail_r];
        end
    end

    // Pointers, occupancy and handshake flags, all held as registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r      <= 1'b0;
            tail_r      <= 1'b0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s != FULL_COUNT);
            out_valid_r <= (count_nxt_s != 2'd0);
        end
    end

    // Registered copy of the head entry's writeback fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r <= 16'h0000;
            out_dest_r <= 3'd0;
        end else begin
            out_data_r <= head_entry_nxt_s.data;
            out_dest_r <= head_entry_nxt_s.dest;
        end
    end

    // Architectural {C, Z, N} flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 3'b000;
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_dest  = out_dest_r;
    assign flags     = flags_r;

endmodule
